// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier and its Alu.
package alu_mul_seq_pkg;

  localparam int ALU_W = 32;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// The lab's 32-bit Alu: AND / OR / ADD / SUB with carry-out, signed overflow and zero flags.
module alu_mul_seq_alu
  import alu_mul_seq_pkg::*;
(
  input  logic [1:0]       alu_ctl,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] r,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  logic [ALU_W:0] sum;

  always_comb begin
    sum      = '0;
    r        = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (alu_ctl)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        r        = sum[ALU_W-1:0];
        cout     = sum[ALU_W];
        overflow = (a[ALU_W-1] == b[ALU_W-1]) && (r[ALU_W-1] != a[ALU_W-1]);
      end
      default: begin
        // Subtract as a + ~b + 1 so cout reads as "no borrow".
        sum      = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
        r        = sum[ALU_W-1:0];
        cout     = sum[ALU_W];
        overflow = (a[ALU_W-1] != b[ALU_W-1]) && (r[ALU_W-1] != a[ALU_W-1]);
      end
    endcase
  end

  assign zero = (r == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH multiplier: 32 shift-and-add iterations through one Alu adder.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               zero
);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_cout;
  logic               alu_ovf_unused;
  logic               alu_zero_unused;
  logic [2*WIDTH-1:0] acc_next;

  assign alu_b = lo[0] ? mcand : '0;

  alu_mul_seq_alu u_alu (
    .alu_ctl  (ALU_ADD),
    .a        (hi),
    .b        (alu_b),
    .r        (alu_r),
    .cout     (alu_cout),
    .overflow (alu_ovf_unused),
    .zero     (alu_zero_unused)
  );

  // Carry-out becomes the new top bit, so the partial sum never loses a bit.
  assign acc_next = {alu_cout, alu_r, lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      zero    <= 1'b0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          {hi, lo} <= acc_next;
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= acc_next;
            zero    <= (acc_next == '0);
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a product/zero scoreboard drained on each done pulse.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        zero;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  logic [64:0] sb_q[$];

  alu_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scoreboard: each done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [64:0] e;
      done_cnt++;
      check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("product", product, e[64:1]);
        check("zero", 64'(zero), 64'(e[0]));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  function automatic logic [64:0] expect_of(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    return {p, (p == 64'd0)};
  endfunction

  // Present operands with start high for the next edge; returns just after that edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit expect_it);
    a = x;
    b = y;
    start = 1'b1;
    if (expect_it) sb_q.push_back(expect_of(x, y));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges from just after the accepting edge until done; busy cycles tallied too.
  task automatic measure(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) break;
      if (lat > 200) begin
        check("done_timeout", 64'(lat), 64'd33);
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int bc;
    int dc0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_zero", 64'(zero), 64'd0);

    @(posedge clk); #1;
    issue(32'd3, 32'd5, 1'b1);
    measure(lat, bc);
    check("lat_3x5", 64'(lat), 64'd33);
    check("busy_3x5", 64'(bc), 64'd32);

    @(posedge clk); #1;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    measure(lat, bc);
    check("lat_max", 64'(lat), 64'd33);

    @(posedge clk); #1;
    issue(32'h1234_5678, 32'd0, 1'b1);
    measure(lat, bc);
    check("lat_b0", 64'(lat), 64'd33);

    @(posedge clk); #1;
    issue(32'd0, 32'h8000_0000, 1'b1);
    measure(lat, bc);
    check("lat_a0", 64'(lat), 64'd33);

    // A start pulse mid-RUN must be ignored.
    @(posedge clk); #1;
    dc0 = done_cnt;
    issue(32'd7, 32'd6, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    issue(32'd9, 32'd9, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("ignored_start_dones", 64'(done_cnt - dc0), 64'd1);
    check("ignored_start_product", product, 64'd42);

    // Back-to-back: new operands taken in the DONE cycle.
    @(posedge clk); #1;
    a = 32'd2;
    b = 32'd3;
    start = 1'b1;
    sb_q.push_back(expect_of(32'd2, 32'd3));
    @(posedge clk);
    #1;
    measure(lat, bc);
    check("lat_b2b_first", 64'(lat), 64'd33);
    a = 32'd4;
    b = 32'd5;
    sb_q.push_back(expect_of(32'd4, 32'd5));
    @(posedge clk);
    #1 start = 1'b0;
    measure(lat, bc);
    check("lat_b2b_second", 64'(lat), 64'd33);
    check("b2b_product", product, 64'd20);

    // Reset in the middle of RUN aborts with no done pulse.
    @(posedge clk); #1;
    dc0 = done_cnt;
    issue(32'd100, 32'd100, 1'b0);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    repeat (40) @(posedge clk);
    check("abort_no_done", 64'(done_cnt - dc0), 64'd0);

    @(posedge clk); #1;
    issue(32'd10, 32'd10, 1'b1);
    measure(lat, bc);
    check("lat_after_abort", 64'(lat), 64'd33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("product_held", product, 64'd100);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 32x32->64 multiplier built from the existing 32-bit Alu, used in ADD mode as the only adder.
- An FSM sequences 32 shift-and-add iterations, one per clock, with a start/busy/done handshake.
- Gives the lab datapath a multiply op without a dedicated multiplier array.
- Sits beside the Alu-based datapath; it is driven by the top-level controller or a testbench.

Parameters:
- WIDTH, 32, operand width; must equal Alu width (Alu is fixed at 32).
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  multiplicand; captured on the accepted start
- b  input  WIDTH  multiplier; captured on the accepted start
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle pulse when the product becomes valid
- product  output  2*WIDTH  registered result; held until the next accepted start or rst
- zero  output  1  registered; high when product == 0; valid with done and held with product

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, product=0, zero=0, counter=0, internal registers cleared. Reset overrides start in the same cycle.
- Reset mid-operation: the operation is aborted at that edge, no done pulse is produced, and the outputs take their reset values.
- Internal registers:
  - mcand[WIDTH] holds a.
  - acc = {hi[WIDTH], lo[WIDTH]}; lo is loaded with b, hi is loaded with 0.
  - cnt[CNT_W].
- Alu hookup:
  - ALUCtl tied to ADD (2'b10).
  - A = hi.
  - B = lo[0] ? mcand : 0.
  - Alu R and Cout are used. Overflow and Zero from the Alu are unused.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0. On start=1, capture a/b, set cnt=0, go to RUN.
  - RUN: busy=1. Each cycle, {hi, lo} <= {Cout, R, lo} >> 1, i.e. hi <= {Cout, R[WIDTH-1:1]} and lo <= {R[0], lo[WIDTH-1:1]}. Then cnt <= cnt+1. When cnt == WIDTH-1, go to DONE and load product/zero from the post-shift value in the same edge.
  - DONE: done=1 for exactly this one cycle, busy=0.
    - If start=1 in this cycle, capture the new operands and go to RUN (back-to-back, no idle bubble).
    - Otherwise go to IDLE.
- Latency: start accepted at edge k -> RUN cycles k+1..k+32 -> done=1 during the cycle after edge k+32. Product and zero are valid from that cycle onward.
- Throughput: one product every 33 cycles with back-to-back starts.
- start while busy=1 is ignored: no queueing, no error flag, and a/b changes are not observed.
- product is not updated during RUN; it keeps the previous result until the final edge.
- Arithmetic:
  - Unsigned.
  - The Alu Cout supplies bit WIDTH of each partial sum, so no carry is lost.
  - The result is exact for all inputs: max FFFFFFFF*FFFFFFFF = FFFFFFFE_00000001.
- Operands equal to 0 do not shorten latency (fixed 32 iterations).

Decomposition:
- Shared package/header holds:
  - ALU op localparams: AND=2'b00, OR=2'b01, ADD=2'b10, SUB=2'b11.
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module: the existing Alu, instantiated once as the adder. The FSM, counter and shift register stay in alu_mul_seq.

Test Plan:
- After rst: a=3, b=5, start for 1 cycle -> busy high for 32 cycles, done pulse exactly 33 cycles after start; product=64'h000000000000000F, zero=0.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001, zero=0 (Cout path exercised).
- a=32'h12345678, b=0 -> product=0, zero=1, latency still 33. Repeat with a=0, b=32'h80000000 -> product=0, zero=1.
- Start with a=7, b=6; at RUN cycle 10 pulse start with a=9, b=9 -> the second start is ignored; product=42, only one done pulse.
- Start held high continuously with a=2, b=3, then a=4, b=5 presented in the DONE cycle -> done pulses 33 cycles apart; products 6, then 20.
- Start a=100, b=100; assert rst at RUN cycle 15 -> next cycle busy=0, done=0, product=0, zero=0; no done pulse follows. A subsequent start with a=10, b=10 yields product=100.
